// File: rtl/bcd_time_pkg.sv
// Shared definitions for the BCD time-of-day counter: BCD limits, the packed
// digit-pair type, the set-handshake state encoding and a range check helper.
package bcd_time_pkg;

    typedef logic [7:0] bcd_pair_t;

    localparam bcd_pair_t BCD_ZERO = 8'h00;
    localparam bcd_pair_t SEC_MAX  = 8'h59;
    localparam bcd_pair_t MIN_MAX  = 8'h59;
    localparam bcd_pair_t HR24_MAX = 8'h23;
    localparam bcd_pair_t HR12_MAX = 8'h12;
    localparam bcd_pair_t HR12_MIN = 8'h01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } set_state_t;

    // The upper bound also caps the tens digit, so only the units digit needs its own check.
    function automatic logic bcd_in_range(input bcd_pair_t v, input bcd_pair_t lo,
                                          input bcd_pair_t hi);
        return (v[3:0] <= 4'd9) && (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter: counts up on enable, wraps from max_val to
// wrap_val, and loads load_val with priority over counting.
module bcd_mod_counter
    import bcd_time_pkg::*;
#(
    parameter bcd_pair_t RST_VAL = 8'h00
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      enable,
    input  logic      load,
    input  bcd_pair_t load_val,
    input  bcd_pair_t max_val,
    input  bcd_pair_t wrap_val,
    output bcd_pair_t value,
    output logic      carry_out
);

    bcd_pair_t next_val;

    always_comb begin
        next_val = value;
        if (value == max_val) begin
            next_val = wrap_val;
        end else if (value[3:0] == 4'd9) begin
            next_val = {value[7:4] + 4'd1, 4'd0};
        end else begin
            next_val = {value[7:4], value[3:0] + 4'd1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= RST_VAL;
        end else if (load) begin
            value <= load_val;
        end else if (enable) begin
            value <= next_val;
        end
    end

    assign carry_out = enable & (value == max_val);

endmodule

// File: rtl/bcd_time_counter.sv
// HH:MM:SS time of day in packed BCD, advanced by ticks recovered from the slow
// divider wave; define HOUR12_EN for 12-hour mode with pm/set_pm ports.
module bcd_time_counter
    import bcd_time_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1000000,
    parameter int PRESC_W       = 20
) (
    input  logic       Clck_in,
    input  logic       reset_Clock,
    input  logic       tick_in,
    input  logic       set_req,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic [7:0] set_ss,
`ifdef HOUR12_EN
    input  logic       set_pm,
    output logic       pm,
`endif
    output logic       set_ack,
    output logic       set_err,
    output logic [7:0] hh_bcd,
    output logic [7:0] mm_bcd,
    output logic [7:0] ss_bcd,
    output logic       sec_pulse,
    output set_state_t fsm_state
);

`ifdef HOUR12_EN
    localparam bcd_pair_t HR_MAX  = HR12_MAX;
    localparam bcd_pair_t HR_MIN  = HR12_MIN;
    localparam bcd_pair_t HR_WRAP = HR12_MIN;
    localparam bcd_pair_t HR_RST  = HR12_MAX;
`else
    localparam bcd_pair_t HR_MAX  = HR24_MAX;
    localparam bcd_pair_t HR_MIN  = BCD_ZERO;
    localparam bcd_pair_t HR_WRAP = BCD_ZERO;
    localparam bcd_pair_t HR_RST  = BCD_ZERO;
`endif

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

    logic               s1, s2, s3, tick_q;
    logic [PRESC_W-1:0] presc;
    logic               sec_adv, load, set_valid;
    logic               ss_carry, mm_carry, hh_carry;
    set_state_t         state;

    // Edge detect is registered once more so a sampled rise reaches the counters three edges later.
    always_ff @(posedge Clck_in or posedge reset_Clock) begin
        if (reset_Clock) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            tick_q    <= 1'b0;
            presc     <= '0;
            sec_pulse <= 1'b0;
        end else begin
            s1        <= tick_in;
            s2        <= s1;
            s3        <= s2;
            tick_q    <= s2 & ~s3;
            sec_pulse <= sec_adv & ~load;
            if (load) begin
                presc <= '0;
            end else if (tick_q) begin
                presc <= (presc == PRESC_LAST) ? '0 : presc + PRESC_W'(1);
            end
        end
    end

    assign sec_adv   = tick_q && (presc == PRESC_LAST);
    assign set_valid = bcd_in_range(set_ss, BCD_ZERO, SEC_MAX)
                    && bcd_in_range(set_mm, BCD_ZERO, MIN_MAX)
                    && bcd_in_range(set_hh, HR_MIN, HR_MAX);
    assign load      = (state == IDLE) && set_req && set_valid;

    // A load landing on the same edge as a second increment wins; the tick is dropped.
    always_ff @(posedge Clck_in or posedge reset_Clock) begin
        if (reset_Clock) begin
            state   <= IDLE;
            set_ack <= 1'b0;
            set_err <= 1'b0;
        end else begin
            set_ack <= 1'b0;
            set_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (set_req) begin
                        if (set_valid) begin
                            state   <= ACK;
                            set_ack <= 1'b1;
                        end else begin
                            state   <= WAIT;
                            set_err <= 1'b1;
                        end
                    end
                end
                ACK:     state <= WAIT;
                WAIT:    if (!set_req) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign fsm_state = state;

    bcd_mod_counter #(.RST_VAL(BCD_ZERO)) u_ss (
        .clk       (Clck_in),
        .rst       (reset_Clock),
        .enable    (sec_adv & ~load),
        .load      (load),
        .load_val  (set_ss),
        .max_val   (SEC_MAX),
        .wrap_val  (BCD_ZERO),
        .value     (ss_bcd),
        .carry_out (ss_carry)
    );

    bcd_mod_counter #(.RST_VAL(BCD_ZERO)) u_mm (
        .clk       (Clck_in),
        .rst       (reset_Clock),
        .enable    (ss_carry),
        .load      (load),
        .load_val  (set_mm),
        .max_val   (MIN_MAX),
        .wrap_val  (BCD_ZERO),
        .value     (mm_bcd),
        .carry_out (mm_carry)
    );

    bcd_mod_counter #(.RST_VAL(HR_RST)) u_hh (
        .clk       (Clck_in),
        .rst       (reset_Clock),
        .enable    (mm_carry),
        .load      (load),
        .load_val  (set_hh),
        .max_val   (HR_MAX),
        .wrap_val  (HR_WRAP),
        .value     (hh_bcd),
        .carry_out (hh_carry)
    );

    // Day rollover has no consumer yet.
    logic unused_hh_carry;
    assign unused_hh_carry = hh_carry;

`ifdef HOUR12_EN
    // Meridiem flips only when the hour advances from 11 to 12.
    always_ff @(posedge Clck_in or posedge reset_Clock) begin
        if (reset_Clock) begin
            pm <= 1'b0;
        end else if (load) begin
            pm <= set_pm;
        end else if (mm_carry && (hh_bcd == 8'h11)) begin
            pm <= ~pm;
        end
    end
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter with TICKS_PER_SEC=4: set-request vector table,
// hand sequences for latency, rollover, coincident load, stuck input and reset.
module tb_bcd_time_counter;
    import bcd_time_pkg::*;

    localparam int TPS = 4;

    typedef struct {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
        logic       pm;
        logic       ok;
        int         hold;
    } set_vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_in = 1'b0;
    logic       set_req = 1'b0;
    logic [7:0] set_hh = 8'h00;
    logic [7:0] set_mm = 8'h00;
    logic [7:0] set_ss = 8'h00;
    logic       set_ack, set_err, sec_pulse;
    logic [7:0] hh, mm, ss;
    set_state_t fsm_state;
    logic       cur_pm;
    logic [24:0] cur_t;

`ifdef HOUR12_EN
    logic set_pm = 1'b0;
    logic pm_out;
    assign cur_pm = pm_out;
    localparam logic [7:0] HH_RST = 8'h12;
`else
    assign cur_pm = 1'b0;
    localparam logic [7:0] HH_RST = 8'h00;
`endif
    assign cur_t = {cur_pm, hh, mm, ss};

    bcd_time_counter #(.TICKS_PER_SEC(TPS), .PRESC_W(20)) dut (
        .Clck_in     (clk),
        .reset_Clock (rst),
        .tick_in     (tick_in),
        .set_req     (set_req),
        .set_hh      (set_hh),
        .set_mm      (set_mm),
        .set_ss      (set_ss),
`ifdef HOUR12_EN
        .set_pm      (set_pm),
        .pm          (pm_out),
`endif
        .set_ack     (set_ack),
        .set_err     (set_err),
        .hh_bcd      (hh),
        .mm_bcd      (mm),
        .ss_bcd      (ss),
        .sec_pulse   (sec_pulse),
        .fsm_state   (fsm_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_pulse = 0;
    logic [24:0] exp_q[$];
    int   m_h, m_m, m_s, m_presc;
    logic m_pm;
    set_vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    function automatic int from_bcd(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [24:0] model_time();
        return {m_pm, to_bcd(m_h), to_bcd(m_m), to_bcd(m_s)};
    endfunction

    task automatic model_reset();
        m_h = from_bcd(HH_RST);
        m_m = 0;
        m_s = 0;
        m_presc = 0;
        m_pm = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_advance();
        m_s++;
        if (m_s == 60) begin
            m_s = 0;
            m_m++;
            if (m_m == 60) begin
                m_m = 0;
`ifdef HOUR12_EN
                if (m_h == 12) begin
                    m_h = 1;
                end else begin
                    m_h++;
                    if (m_h == 12) m_pm = ~m_pm;
                end
`else
                m_h = (m_h + 1) % 24;
`endif
            end
        end
    endtask

    task automatic model_tick();
        m_presc++;
        if (m_presc == TPS) begin
            m_presc = 0;
            model_advance();
            exp_q.push_back(model_time());
        end
    endtask

    task automatic model_load(input logic [7:0] h, input logic [7:0] mn, input logic [7:0] s,
                              input logic p);
        m_h = from_bcd(h);
        m_m = from_bcd(mn);
        m_s = from_bcd(s);
        m_presc = 0;
`ifdef HOUR12_EN
        m_pm = p;
`else
        m_pm = 1'b0;
        if (p) m_pm = 1'b0;
`endif
    endtask

    task automatic do_tick(input int hi, input int lo);
        @(posedge clk);
        #1 tick_in = 1'b1;
        model_tick();
        repeat (hi) @(posedge clk);
        #1 tick_in = 1'b0;
        repeat (lo) @(posedge clk);
    endtask

    task automatic apply_set(input set_vec_t v);
        int na;
        int ne;
        na = 0;
        ne = 0;
        @(posedge clk);
        #1;
        set_req = 1'b1;
        set_hh  = v.hh;
        set_mm  = v.mm;
        set_ss  = v.ss;
`ifdef HOUR12_EN
        set_pm  = v.pm;
`endif
        repeat (v.hold) begin
            @(negedge clk);
            na += int'(set_ack);
            ne += int'(set_err);
        end
        @(posedge clk);
        #1 set_req = 1'b0;
        repeat (4) begin
            @(negedge clk);
            na += int'(set_ack);
            ne += int'(set_err);
        end
        if (v.ok) model_load(v.hh, v.mm, v.ss, v.pm);
        check("set_ack_count", 32'(na), v.ok ? 32'd1 : 32'd0);
        check("set_err_count", 32'(ne), v.ok ? 32'd0 : 32'd1);
        check("time_after_set", 32'(cur_t), 32'(model_time()));
    endtask

    // Scoreboard: every second increment must match the next queued model time.
    always @(negedge clk) begin
        if (!rst) begin
            check("nibbles_le_9",
                  32'((hh[7:4] <= 4'd9) && (hh[3:0] <= 4'd9) && (mm[7:4] <= 4'd9) &&
                      (mm[3:0] <= 4'd9) && (ss[7:4] <= 4'd9) && (ss[3:0] <= 4'd9)), 32'd1);
            if (sec_pulse) begin
                n_pulse++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_sec_pulse: got time %h expected no pulse", cur_t);
                end else begin
                    check("sec_time", 32'(cur_t), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
`ifdef HOUR12_EN
        vecs.push_back('{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 2});
        vecs.push_back('{8'h13, 8'h00, 8'h00, 1'b0, 1'b0, 3});
        vecs.push_back('{8'h01, 8'h5A, 8'h00, 1'b0, 1'b0, 2});
        vecs.push_back('{8'h12, 8'h34, 8'h56, 1'b1, 1'b1, 10});
        vecs.push_back('{8'h0A, 8'h00, 8'h00, 1'b0, 1'b0, 1});
        vecs.push_back('{8'h01, 8'h00, 8'h00, 1'b0, 1'b1, 1});
        vecs.push_back('{8'h11, 8'h59, 8'h30, 1'b1, 1'b1, 4});
`else
        vecs.push_back('{8'h24, 8'h00, 8'h00, 1'b0, 1'b0, 2});
        vecs.push_back('{8'h00, 8'h5A, 8'h00, 1'b0, 1'b0, 3});
        vecs.push_back('{8'h00, 8'h00, 8'h60, 1'b0, 1'b0, 1});
        vecs.push_back('{8'h1A, 8'h00, 8'h00, 1'b0, 1'b0, 2});
        vecs.push_back('{8'h12, 8'h34, 8'h56, 1'b0, 1'b1, 10});
        vecs.push_back('{8'h23, 8'h59, 8'h59, 1'b0, 1'b1, 1});
        vecs.push_back('{8'h09, 8'h0F, 8'h00, 1'b0, 1'b0, 2});
        vecs.push_back('{8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 4});
        vecs.push_back('{8'h19, 8'h45, 8'h09, 1'b0, 1'b1, 3});
`endif
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_time", 32'(cur_t), 32'({1'b0, HH_RST, 16'h0000}));
        check("reset_pulses", 32'({set_ack, set_err, sec_pulse}), 32'd0);
        check("reset_fsm", 32'(fsm_state), 32'(IDLE));
        @(posedge clk);
        #1 rst = 1'b0;

        // First second: exact latency of the fourth tick
        repeat (3) do_tick(3, 3);
        @(posedge clk);
        #1 tick_in = 1'b1;
        model_tick();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_edge_pulse", 32'(sec_pulse), 32'd0);
        check("pre_edge_ss", 32'(ss), 32'h00);
        @(posedge clk);
        @(negedge clk);
        check("first_pulse", 32'(sec_pulse), 32'd1);
        check("first_time", 32'({hh, mm, ss}), 32'({HH_RST, 16'h0001}));
        @(posedge clk);
        #1 tick_in = 1'b0;
        @(negedge clk);
        check("pulse_one_cycle", 32'(sec_pulse), 32'd0);
        repeat (3) @(posedge clk);

        // Set-request table, one tick between entries to keep the prescaler busy
        foreach (vecs[i]) begin
            apply_set(vecs[i]);
            do_tick(3, 3);
        end

`ifndef HOUR12_EN
        // Full-day rollover
        apply_set('{8'h23, 8'h59, 8'h58, 1'b0, 1'b1, 2});
        p0 = n_pulse;
        repeat (8) do_tick(3, 3);
        check("rollover_time", 32'({hh, mm, ss}), 32'h000000);
        check("rollover_pulses", 32'(n_pulse - p0), 32'd2);
`else
        apply_set('{8'h11, 8'h59, 8'h59, 1'b0, 1'b1, 2});
        repeat (4) do_tick(3, 3);
        check("pm_toggle", 32'(cur_t), 32'({1'b1, 24'h120000}));
        apply_set('{8'h12, 8'h59, 8'h59, 1'b1, 1'b1, 2});
        repeat (4) do_tick(3, 3);
        check("hour12_wrap", 32'(cur_t), 32'({1'b1, 24'h010000}));
        p0 = n_pulse;
`endif

        // Load coincident with the second increment
        while (m_presc != TPS - 1) do_tick(3, 3);
        @(posedge clk);
        #1 tick_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        set_req = 1'b1;
        set_hh  = 8'h07;
        set_mm  = 8'h30;
        set_ss  = 8'h15;
`ifdef HOUR12_EN
        set_pm  = 1'b0;
`endif
        @(posedge clk);
        model_load(8'h07, 8'h30, 8'h15, 1'b0);
        @(negedge clk);
        check("coincident_ack", 32'(set_ack), 32'd1);
        check("coincident_pulse", 32'(sec_pulse), 32'd0);
        check("coincident_load", 32'({hh, mm, ss}), 32'h073015);
        @(posedge clk);
        #1;
        set_req = 1'b0;
        tick_in = 1'b0;
        repeat (4) @(posedge clk);
        repeat (3) do_tick(3, 3);
        check("no_early_second", 32'({hh, mm, ss}), 32'h073015);
        do_tick(3, 3);
        check("second_after_coincident", 32'({hh, mm, ss}), 32'h073016);

        // Stuck high then stuck low: only the single rise counts
        p0 = m_presc;
        do_tick(40, 40);
        check("stuck_one_tick", 32'(m_presc), 32'((p0 + 1) % TPS));
        repeat (TPS - 1 - m_presc) do_tick(3, 3);
        check("stuck_time", 32'({hh, mm, ss}), 32'h073016);
        do_tick(3, 3);
        check("after_stuck_time", 32'({hh, mm, ss}), 32'h073017);

        // Async reset mid-count
        apply_set('{8'h01, 8'h00, 8'h17, 1'b0, 1'b1, 2});
        repeat (2) do_tick(3, 3);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_reset_time", 32'(cur_t), 32'({1'b0, HH_RST, 16'h0000}));
        check("async_reset_pulses", 32'({set_ack, set_err, sec_pulse}), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) do_tick(3, 3);
        check("post_reset_hold", 32'(ss), 32'h00);
        do_tick(3, 3);
        check("post_reset_second", 32'(ss), 32'h01);

        // Reset drops a pending acknowledge
        @(posedge clk);
        #1;
        set_req = 1'b1;
        set_hh  = 8'h05;
        set_mm  = 8'h06;
        set_ss  = 8'h07;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("ack_dropped", 32'(set_ack), 32'd0);
        check("ack_reset_time", 32'(cur_t), 32'({1'b0, HH_RST, 16'h0000}));
        check("ack_reset_fsm", 32'(fsm_state), 32'(IDLE));
        set_req = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;

        repeat (10) @(posedge clk);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
